// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Combinational only: state encoding, bubble encoding and PC step.
// No flow control of its own.
package fetch_pkg;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

   // addi x0,x0,0 - what IF/ID sees when nothing real is being presented
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/if_fetch_buf.sv
// One-entry holding register for the instruction presented to IF/ID.
// Outputs registered; a load is visible the cycle after the load edge.
// Entry persists until consumed or cleared; clear beats load beats consume.
module if_fetch_buf
   import fetch_pkg::*;
#(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] NOP   = NOP_INSTR
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             consume,
   input  logic             clear,
   input  logic [WIDTH-1:0] load_pc,
   input  logic [WIDTH-1:0] load_instr,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] instr,
   output logic             valid
);

   // Entry update: a clear (redirect) always wins so a squashed fetch never shows up;
   // an emptied entry shows the bubble encoding, and the stale pc is left in place.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc    <= '0;
         instr <= NOP;
         valid <= 1'b0;
      end else if (clear) begin
         instr <= NOP;
         valid <= 1'b0;
      end else if (load) begin
         pc    <= load_pc;
         instr <= load_instr;
         valid <= 1'b1;
      end else if (consume) begin
         instr <= NOP;
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, one outstanding imem read, presents to IF/ID.
// Request to presented instruction: 2 cycles with a 1-cycle memory; 1 instruction per 3 cycles.
// Stall holds the presented instruction; imem_addr is held while a request waits for ready.
module if_fetch_unit
   import fetch_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter logic [WIDTH-1:0] NOP      = NOP_INSTR
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_rsp_valid,
   input  logic [WIDTH-1:0] imem_rsp_data,
   output logic [WIDTH-1:0] pc_if,
   output logic [WIDTH-1:0] instr_if,
   output logic             valid_if
);

   fetch_state_t     state;
   logic [WIDTH-1:0] pc_next;
   logic             drop;

   logic             accept;
   logic             consume;
   logic             rsp;
   logic             buf_load;
   logic [WIDTH-1:0] redirect_aligned;
   logic [WIDTH-1:0] pc_incr;
   logic             redirect_lsb_unused;

   // Fetch addresses are always word aligned; the low redirect bits are ignored.
   assign redirect_aligned    = {redirect_pc[WIDTH-1:2], 2'b00};
   assign redirect_lsb_unused = ^redirect_pc[1:0];
   assign pc_incr             = pc_next + WIDTH'(PC_STEP);

   // Request valid is decoded from state; held low while reset is asserted so the
   // first request appears in the cycle right after rst falls.
   assign imem_req_valid = (state == REQ) && !rst;
   assign accept         = imem_req_valid && imem_req_ready;
   assign consume        = valid_if && !stall;
   // A response is only meaningful while waiting for one; anything else is ignored.
   assign rsp            = imem_rsp_valid && (state == WAIT);
   assign buf_load       = rsp && !drop && !redirect_valid;

   // Fetch FSM with pc_next, drop flag and request address as registered state.
   // imem_addr follows pc_next except while a request sits un-accepted in REQ.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= REQ;
         pc_next   <= RESET_PC;
         drop      <= 1'b0;
         imem_addr <= RESET_PC;
      end else if (redirect_valid) begin
         pc_next <= redirect_aligned;
         case (state)
            REQ: begin
               // A pending request cannot be withdrawn; its data will be thrown away.
               drop <= 1'b1;
               if (accept) begin
                  state     <= WAIT;
                  imem_addr <= redirect_aligned;
               end
            end
            WAIT: begin
               imem_addr <= redirect_aligned;
               if (rsp) begin
                  // The outstanding read returns on this very edge: nothing left to drop.
                  state <= REQ;
                  drop  <= 1'b0;
               end else begin
                  drop <= 1'b1;
               end
            end
            default: begin
               state     <= REQ;
               imem_addr <= redirect_aligned;
            end
         endcase
      end else begin
         case (state)
            REQ: begin
               if (accept) begin
                  state     <= WAIT;
                  imem_addr <= pc_next;
               end
            end
            WAIT: begin
               if (rsp) begin
                  if (drop) begin
                     drop  <= 1'b0;
                     state <= REQ;
                  end else begin
                     pc_next   <= pc_incr;
                     imem_addr <= pc_incr;
                     state     <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (consume) begin
                  state <= REQ;
               end
            end
            default: begin
               state <= REQ;
               drop  <= 1'b0;
            end
         endcase
      end
   end

   if_fetch_buf #(
      .WIDTH (WIDTH),
      .NOP   (NOP)
   ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .load       (buf_load),
      .consume    (consume),
      .clear      (redirect_valid),
      .load_pc    (pc_next),
      .load_instr (imem_rsp_data),
      .pc         (pc_if),
      .instr      (instr_if),
      .valid      (valid_if)
   );

   // Memory must only answer a request that is actually outstanding.
   a_rsp_only_in_wait : assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> (state == WAIT));

endmodule
